// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: buffers stereo frames from the CLK domain and shifts them out on AUD_DACDAT
// against the codec-mastered AUD_BCLK / AUD_DACLRCK. Optional macro: I2S_TX_REPEAT_LAST_EN.
module i2s_dac_transmitter #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               AUD_BCLK,
  input  logic                               AUD_DACLRCK,
  output logic                               AUD_DACDAT,
  input  logic [31:0]                        in_left,
  input  logic [31:0]                        in_right,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun,
  input  logic                               underrun_clr,
  output logic [1:0]                         dbg_state
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_prev;
  logic                   lrck_d;
  logic                   lrck_last;
  logic                   fe;
  logic                   to_left;
  logic                   to_right;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    underrun_set;

  logic [DATA_WIDTH-1:0] frame_left;
  logic [DATA_WIDTH-1:0] frame_right;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] head_left;
  logic [DATA_WIDTH-1:0] head_right;
  logic [DATA_WIDTH-1:0] entry_left;
  logic [DATA_WIDTH-1:0] entry_right;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_prev <= bclk_s;
      lrck_d    <= lrck_s;
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];
  assign fe     = bclk_prev & ~bclk_s;

  // LRCK moves on the BCLK falling edge; looking at it one CLK late makes each fe see the
  // level from before that edge, which yields the one-bit I2S delay.
  assign to_left  = fe && (lrck_d != lrck_last) && !lrck_d;
  assign to_right = fe && (lrck_d != lrck_last) && lrck_d;

  // Handshake: a frame transfers on every CLK where in_valid and in_ready are both high;
  // in_ready is low only while the FIFO is full or RESET is asserted.
  assign in_ready     = !RESET && (fifo_level != LW'(FIFO_DEPTH));
  assign push         = in_valid && in_ready;
  assign fifo_empty   = (fifo_level == '0);
  assign pop          = to_left && !fifo_empty;
  assign underrun_set = to_left && fifo_empty;

  assign head_left  = mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_right = mem[rd_ptr][DATA_WIDTH-1:0];

  always_comb begin
    entry_left  = head_left;
    entry_right = head_right;
    if (fifo_empty) begin
`ifdef I2S_TX_REPEAT_LAST_EN
      entry_left  = frame_left;
      entry_right = frame_right;
`else
      entry_left  = '0;
      entry_right = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {in_left[31 -: DATA_WIDTH], in_right[31 -: DATA_WIDTH]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A set in the same CLK as a clear wins, so no underrun event is lost.
  always_ff @(posedge CLK) begin
    if (RESET)             underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_SYNC;
      lrck_last   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      shift_reg   <= '0;
      AUD_DACDAT  <= 1'b0;
    end else if (fe) begin
      lrck_last <= lrck_d;
      if (to_left) begin
        state       <= ST_LEFT;
        frame_left  <= entry_left;
        frame_right <= entry_right;
        AUD_DACDAT  <= entry_left[DATA_WIDTH-1];
        shift_reg   <= {entry_left[DATA_WIDTH-2:0], 1'b0};
      end else begin
        case (state)
          ST_SYNC: begin
            AUD_DACDAT <= 1'b0;
          end
          ST_LEFT: begin
            if (to_right) begin
              state      <= ST_RIGHT;
              AUD_DACDAT <= frame_right[DATA_WIDTH-1];
              shift_reg  <= {frame_right[DATA_WIDTH-2:0], 1'b0};
            end else begin
              AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
              shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            end
          end
          ST_RIGHT: begin
            AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
            shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
          default: begin
            state      <= ST_SYNC;
            AUD_DACDAT <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

  if (DATA_WIDTH < 32) begin : g_unused_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^{in_left[31-DATA_WIDTH:0], in_right[31-DATA_WIDTH:0]};
  end

endmodule
